// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: cache line width, line type, arbiter states.
// Latency: none (type definitions only).
// Backpressure: none (type definitions only).
package rv32i_types;

  // One cache line is 32 bytes.
  localparam int LINE_WIDTH = 256;

  typedef logic [LINE_WIDTH-1:0] cacheline_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Side most recently granted; a tie goes to the other side.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and memory line-transfer signals around the arbiter.
// Latency: none (wiring only).
// Backpressure: a request is held by its cache until the matching resp pulse.
// Ports: slave = arbiter view (cache requests and memory data in, strobes/resps out);
//        master = environment view (caches and memory), directions reversed.
interface cache_arbiter_if;
  import rv32i_types::*;

  // I-cache side
  logic        i_pmem_read;
  logic [31:0] i_pmem_address;
  cacheline_t  i_pmem_rdata;
  logic        i_pmem_resp;

  // D-cache side
  logic        d_pmem_read;
  logic        d_pmem_write;
  logic [31:0] d_pmem_address;
  cacheline_t  d_pmem_wdata;
  cacheline_t  d_pmem_rdata;
  logic        d_pmem_resp;

  // Memory side
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  cacheline_t  pmem_wdata;
  cacheline_t  pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto one memory port, one transaction at a time.
// Latency: grant the cycle after a request is seen in IDLE; cache resp in the pmem_resp cycle.
// Backpressure: losing side keeps its request high and is served after the DONE cycle.
// Ports: clk, rst (sync, active high); bus = cache_arbiter_if.slave carrying all cache/memory signals.
module cache_arbiter
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  arb_state_t  state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  cacheline_t  wdata_q, wdata_d;
  logic        write_q, write_d;

  logic        i_req, d_req;
  logic        rd_c, wr_c, i_resp_c, d_resp_c;
  logic [31:0] addr_c;
  cacheline_t  wdata_c;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    rd_c         = 1'b0;
    wr_c         = 1'b0;
    i_resp_c     = 1'b0;
    d_resp_c     = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;

    i_req = bus.i_pmem_read;
    d_req = bus.d_pmem_read | bus.d_pmem_write;

    unique case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D was served last.
        if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
          state_d      = I_BUSY;
          last_grant_d = GRANT_I;
          addr_d       = bus.i_pmem_address;
          wdata_d      = '0;
          write_d      = 1'b0;
        end else if (d_req) begin
          state_d      = D_BUSY;
          last_grant_d = GRANT_D;
          addr_d       = bus.d_pmem_address;
          wdata_d      = bus.d_pmem_wdata;
          // Read and write both high means a write-back.
          write_d      = bus.d_pmem_write;
        end
      end
      I_BUSY, D_BUSY: begin
        rd_c    = ~write_q;
        wr_c    = write_q;
        addr_c  = addr_q;
        wdata_c = wdata_q;
        if (bus.pmem_resp) begin
          i_resp_c = (state_q == I_BUSY);
          d_resp_c = (state_q == D_BUSY);
          state_d  = DONE;
        end
      end
      DONE: begin
        // One quiet cycle so the served cache can drop its request.
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, even mid-transaction.
    if (rst) begin
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      i_resp_c = 1'b0;
      d_resp_c = 1'b0;
      addr_c   = '0;
      wdata_c  = '0;
    end
  end

  assign bus.pmem_read    = rd_c;
  assign bus.pmem_write   = wr_c;
  assign bus.pmem_address = addr_c;
  assign bus.pmem_wdata   = wdata_c;
  assign bus.i_pmem_resp  = i_resp_c;
  assign bus.d_pmem_resp  = d_resp_c;
  // Read data goes to both caches; only resp tells a cache the data is its own.
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with an expected-grant scoreboard.
// Latency: checks grant one cycle after an IDLE request and resp in the pmem_resp cycle.
// Backpressure: models caches holding requests until resp, then dropping them in DONE.
module tb_cache_arbiter;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    grant_t      side;
    logic        write;
    logic [31:0] addr;
    cacheline_t  wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input grant_t side, input logic wr, input logic [31:0] addr, input cacheline_t wd);
    exp_t e;
    e.side  = side;
    e.write = wr;
    e.addr  = addr;
    e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 256'({bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
  endtask

  // Waits for the next grant, checks it against the scoreboard head, holds it for
  // `hold` cycles, returns `rd` with pmem_resp, then drops the served request in DONE.
  task automatic serve(input int lat, input cacheline_t rd, input int hold, input bit churn);
    exp_t e;
    int   n = 0;
    #1;
    while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("grant_latency", 256'(n), 256'(lat));
    check("sb_depth", 256'(sb.size() != 0), 256'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("pmem_address", 256'(bus.pmem_address), 256'(e.addr));
    check("pmem_op", 256'({bus.pmem_read, bus.pmem_write}), 256'({!e.write, e.write}));
    if (e.write) check("pmem_wdata", bus.pmem_wdata, e.wdata);
    for (int i = 0; i < hold; i++) begin
      if (churn) begin
        bus.d_pmem_address = 32'hFFFF_FFE0;
        bus.d_pmem_wdata   = ~bus.d_pmem_wdata;
      end
      @(posedge clk);
      #2;
      check("hold_address", 256'(bus.pmem_address), 256'(e.addr));
      check("hold_op", 256'({bus.pmem_read, bus.pmem_write}), 256'({!e.write, e.write}));
      if (e.write) check("hold_wdata", bus.pmem_wdata, e.wdata);
      check("hold_no_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    end
    @(posedge clk);
    #1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    #1;
    check("resp_side", 256'({bus.i_pmem_resp, bus.d_pmem_resp}),
          256'((e.side == GRANT_I) ? 2'b10 : 2'b01));
    check("resp_strobe_held", 256'({bus.pmem_read, bus.pmem_write}), 256'({!e.write, e.write}));
    check("i_rdata", bus.i_pmem_rdata, rd);
    check("d_rdata", bus.d_pmem_rdata, rd);
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
    if (e.side == GRANT_I) bus.i_pmem_read = 1'b0;
    else begin
      bus.d_pmem_read  = 1'b0;
      bus.d_pmem_write = 1'b0;
    end
    #1;
    check_quiet("done_quiet");
  endtask

  initial begin
    cacheline_t line_a5, line_1234, line_c3;
    line_a5   = {32{8'hA5}};
    line_1234 = {16{16'h1234}};
    line_c3   = {32{8'hC3}};

    rst                = 1'b1;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;

    // Reset state, during and one cycle after reset.
    step();
    #1;
    check_quiet("rst_quiet");
    check("rst_addr", 256'(bus.pmem_address), 256'(0));
    check("rst_wdata", bus.pmem_wdata, '0);
    step();
    rst = 1'b0;
    #1;
    check_quiet("post_rst_quiet");
    check("post_rst_addr", 256'(bus.pmem_address), 256'(0));
    check("post_rst_wdata", bus.pmem_wdata, '0);
    check("post_rst_state", 256'(dut.state_q), 256'(IDLE));

    // Tie right after reset: I first, then D from the IDLE after DONE.
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0100;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_0200;
    push(GRANT_I, 1'b0, 32'h0000_0100, '0);
    push(GRANT_D, 1'b0, 32'h0000_0200, '0);
    serve(1, line_c3, 0, 1'b0);
    serve(2, ~line_c3, 1, 1'b0);

    // Second tie: D was served last, so I again wins.
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0140;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_0240;
    push(GRANT_I, 1'b0, 32'h0000_0140, '0);
    push(GRANT_D, 1'b0, 32'h0000_0240, '0);
    serve(1, line_a5, 0, 1'b0);
    serve(2, line_c3, 0, 1'b0);

    // I only: strobe cycles 1-4, resp in cycle 4.
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0060;
    push(GRANT_I, 1'b0, 32'h0000_0060, '0);
    serve(1, line_a5, 2, 1'b0);

    // Tie with I served last: D first this time.
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0180;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_0280;
    push(GRANT_D, 1'b0, 32'h0000_0280, '0);
    push(GRANT_I, 1'b0, 32'h0000_0180, '0);
    serve(1, line_1234, 0, 1'b0);
    serve(2, line_a5, 0, 1'b0);

    // D write-back with address/data churn while busy.
    step();
    bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_1000; bus.d_pmem_wdata = line_1234;
    push(GRANT_D, 1'b1, 32'h0000_1000, line_1234);
    serve(1, '0, 3, 1'b1);

    // D read and write both high is a write.
    step();
    bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1;
    bus.d_pmem_address = 32'h0000_2020; bus.d_pmem_wdata = line_c3;
    push(GRANT_D, 1'b1, 32'h0000_2020, line_c3);
    serve(1, '0, 1, 1'b0);

    // Stray pmem_resp in IDLE.
    step();
    bus.pmem_resp = 1'b1;
    #1;
    check_quiet("stray_resp_quiet");
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check("stray_state", 256'(dut.state_q), 256'(IDLE));
    check_quiet("stray_after_quiet");

    // Reset during I_BUSY, then a late pmem_resp.
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0300;
    step();
    #1;
    check("abort_grant", 256'({bus.pmem_read, bus.pmem_address}), 256'({1'b1, 32'h0000_0300}));
    step();
    rst = 1'b1;
    bus.i_pmem_read = 1'b0;
    #1;
    check_quiet("abort_rst_quiet");
    step();
    rst = 1'b0;
    #1;
    check_quiet("abort_after_quiet");
    check("abort_state", 256'(dut.state_q), 256'(IDLE));
    step();
    bus.pmem_resp = 1'b1;
    #1;
    check_quiet("abort_late_resp");
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check("abort_final_state", 256'(dut.state_q), 256'(IDLE));

    // Reset restores last grant to D, so a tie goes to I.
    step();
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_0400;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_0500;
    push(GRANT_I, 1'b0, 32'h0000_0400, '0);
    push(GRANT_D, 1'b0, 32'h0000_0500, '0);
    serve(1, line_1234, 0, 1'b0);
    serve(2, line_a5, 0, 1'b0);

    check("sb_drained", 256'(sb.size()), 256'(0));
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
